// File: rtl/alu_core_if.sv
// Operand/result bundle for alu_core: operands and opcode in, registered 64-bit result out.
// Latency: none (wiring only); results arrive one cycle after their operands.
// Backpressure: none; a new operation is accepted every cycle.
interface alu_core_if;
  logic [31:0] A;
  logic [31:0] B;
  logic [4:0]  op;
  logic [31:0] result_low;
  logic [31:0] result_high;

  // Driver side: supplies operands and opcode, observes results.
  modport master (
    output A, B, op,
    input  result_low, result_high
  );

  // ALU side: consumes operands and opcode, drives results.
  modport slave (
    input  A, B, op,
    output result_low, result_high
  );
endinterface

// File: rtl/alu_core.sv
// 32-bit ALU: thirteen ops (logic, CLA add/sub, shifts, rotates, signed mul/div) into a 64-bit result.
// Latency: 1 cycle, result registered at the edge that samples the operands; throughput 1 op/cycle.
// Backpressure: none; operands are taken every cycle, clear low synchronously zeroes the result.
module alu_core (
  input  logic        clk,
  input  logic        clear,
  alu_core_if.slave   bus
);

  typedef enum logic [4:0] {
    OP_AND  = 5'd0,
    OP_OR   = 5'd1,
    OP_ADD  = 5'd2,
    OP_SUB  = 5'd3,
    OP_SHR  = 5'd4,
    OP_SHRA = 5'd5,
    OP_SHL  = 5'd6,
    OP_ROR  = 5'd7,
    OP_ROL  = 5'd8,
    OP_MUL  = 5'd9,
    OP_DIV  = 5'd10,
    OP_NEG  = 5'd11,
    OP_NOT  = 5'd12
  } op_e;

  logic [31:0] add_b;
  logic        add_cin;
  logic [31:0] p, g, c;
  logic [7:0]  gp, gg;
  logic [8:0]  gc;
  logic [31:0] add_sum;
  logic        add_cout;

  logic [4:0]  sh;
  logic [63:0] prod;
  logic signed [31:0] sa, sb;
  logic [31:0] quot, rem;

  logic [31:0] nxt_low, nxt_high;

  // Carry-lookahead adder shared by ADD and SUB: 4-bit groups, group P/G feeding a second lookahead level.
  always_comb begin
    add_b   = (bus.op == OP_SUB) ? ~bus.B : bus.B;
    add_cin = (bus.op == OP_SUB);
    p  = bus.A ^ add_b;
    g  = bus.A & add_b;
    gp = '0;
    gg = '0;
    gc = '0;
    c  = '0;
    for (int j = 0; j < 8; j++) begin
      gp[j] = p[4*j+3] & p[4*j+2] & p[4*j+1] & p[4*j];
      gg[j] = g[4*j+3]
            | (p[4*j+3] & g[4*j+2])
            | (p[4*j+3] & p[4*j+2] & g[4*j+1])
            | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
    end
    gc[0] = add_cin;
    for (int j = 0; j < 8; j++) begin
      gc[j+1] = gg[j] | (gp[j] & gc[j]);
    end
    for (int j = 0; j < 8; j++) begin
      c[4*j]   = gc[j];
      c[4*j+1] = g[4*j] | (p[4*j] & gc[j]);
      c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & gc[j]);
      c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j])
               | (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
    end
    add_sum  = p ^ c;
    add_cout = gc[8];
  end

  // Signed multiply and divide, including the divide-by-zero and most-negative / -1 corner cases.
  always_comb begin
    prod = {{32{bus.A[31]}}, bus.A} * {{32{bus.B[31]}}, bus.B};
    sa   = bus.A;
    sb   = bus.B;
    quot = '0;
    rem  = '0;
    if (bus.B == 32'd0) begin
      quot = 32'hFFFF_FFFF;
      rem  = bus.A;
    end else if (bus.A == 32'h8000_0000 && bus.B == 32'hFFFF_FFFF) begin
      quot = 32'h8000_0000;
      rem  = 32'd0;
    end else begin
      quot = sa / sb;
      rem  = sa % sb;
    end
  end

  // Opcode decode into the next low/high words; reserved opcodes fall through to zero.
  always_comb begin
    nxt_low  = '0;
    nxt_high = '0;
    sh       = bus.B[4:0];
    case (bus.op)
      OP_AND:  nxt_low = bus.A & bus.B;
      OP_OR:   nxt_low = bus.A | bus.B;
      OP_ADD,
      OP_SUB: begin
        nxt_low  = add_sum;
        nxt_high = {31'd0, add_cout};
      end
      OP_SHR:  nxt_low = bus.A >> sh;
      OP_SHRA: nxt_low = $unsigned($signed(bus.A) >>> sh);
      OP_SHL:  nxt_low = bus.A << sh;
      // A shift by 32 yields zero, so amount 0 leaves A unchanged without a special case.
      OP_ROR:  nxt_low = (bus.A >> sh) | (bus.A << (6'd32 - {1'b0, sh}));
      OP_ROL:  nxt_low = (bus.A << sh) | (bus.A >> (6'd32 - {1'b0, sh}));
      OP_MUL: begin
        nxt_low  = prod[31:0];
        nxt_high = prod[63:32];
      end
      OP_DIV: begin
        nxt_low  = quot;
        nxt_high = rem;
      end
      OP_NEG:  nxt_low = 32'd0 - bus.B;
      OP_NOT:  nxt_low = ~bus.B;
      default: begin
        nxt_low  = '0;
        nxt_high = '0;
      end
    endcase
  end

  // Result register; clear low discards whatever would have been captured this edge.
  always_ff @(posedge clk) begin
    if (!clear) begin
      bus.result_low  <= '0;
      bus.result_high <= '0;
    end else begin
      bus.result_low  <= nxt_low;
      bus.result_high <= nxt_high;
    end
  end

endmodule

// File: tb/tb_alu_core.sv
// Directed bench for alu_core: hand-computed vectors, each checked one cycle after it is applied.
// Latency: expects results exactly one rising edge after the operands are driven.
// Backpressure: none; operands change every cycle in the back-to-back section.
module tb_alu_core;
  logic clk;
  logic clear;
  int   n_vec;
  int   n_err;

  alu_core_if bus ();

  alu_core dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive on the falling edge, let one rising edge capture, then sample 1 time unit later.
  task automatic step(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.op = o;
    bus.A  = a;
    bus.B  = b;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] exp_lo, input logic [31:0] exp_hi);
    n_vec++;
    assert (bus.result_low === exp_lo)
      else begin
        n_err++;
        $error("FAIL %s low: observed %h expected %h", tag, bus.result_low, exp_lo);
      end
    n_vec++;
    assert (bus.result_high === exp_hi)
      else begin
        n_err++;
        $error("FAIL %s high: observed %h expected %h", tag, bus.result_high, exp_hi);
      end
  endtask

  initial begin
    n_vec  = 0;
    n_err  = 0;
    clear  = 1'b0;
    bus.op = 5'd9;
    bus.A  = 32'hFFFF_FFFF;
    bus.B  = 32'd1;

    // Reset held for two edges with a MUL that would otherwise give nonzero words.
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset", 32'd0, 32'd0);

    @(negedge clk);
    clear = 1'b1;

    // ADD, including the carry out.
    step(5'd2, 32'hF000_0000, 32'h00FF_0000); check("add", 32'hF0FF_0000, 32'd0);
    step(5'd2, 32'hFFFF_FFFF, 32'd1);         check("add_carry", 32'd0, 32'd1);

    // SUB borrow / no-borrow, NEG.
    step(5'd3, 32'd5, 32'd7);                 check("sub_borrow", 32'hFFFF_FFFE, 32'd0);
    step(5'd3, 32'd7, 32'd5);                 check("sub_noborrow", 32'd2, 32'd1);
    step(5'd11, 32'h1234_5678, 32'd1);        check("neg", 32'hFFFF_FFFF, 32'd0);
    step(5'd11, 32'd0, 32'h8000_0000);        check("neg_min", 32'h8000_0000, 32'd0);

    // Shifts and rotates by 4, plus amount 0 and ignored upper amount bits.
    step(5'd4, 32'h8000_0001, 32'd4);         check("shr", 32'h0800_0000, 32'd0);
    step(5'd5, 32'h8000_0001, 32'd4);         check("shra", 32'hF800_0000, 32'd0);
    step(5'd6, 32'h8000_0001, 32'd4);         check("shl", 32'h0000_0010, 32'd0);
    step(5'd7, 32'h8000_0001, 32'd4);         check("ror", 32'h1800_0000, 32'd0);
    step(5'd8, 32'h8000_0001, 32'd4);         check("rol", 32'h0000_0018, 32'd0);
    step(5'd7, 32'h8000_0001, 32'h0000_0020); check("ror_zero", 32'h8000_0001, 32'd0);
    step(5'd8, 32'h8000_0001, 32'd0);         check("rol_zero", 32'h8000_0001, 32'd0);
    step(5'd4, 32'h8000_0001, 32'hFFFF_FFE4); check("shr_hibits", 32'h0800_0000, 32'd0);

    // MUL and DIV, including the divide corner cases.
    step(5'd9, 32'hFFFF_FFFE, 32'd3);         check("mul", 32'hFFFF_FFFA, 32'hFFFF_FFFF);
    step(5'd10, 32'hFFFF_FFF9, 32'd2);        check("div_neg", 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    step(5'd10, 32'd7, 32'hFFFF_FFFE);        check("div_negdiv", 32'hFFFF_FFFD, 32'd1);
    step(5'd10, 32'd9, 32'd0);                check("div_zero", 32'hFFFF_FFFF, 32'd9);
    step(5'd10, 32'h8000_0000, 32'hFFFF_FFFF); check("div_ovf", 32'h8000_0000, 32'd0);

    // Back-to-back ops and reserved opcodes.
    step(5'd0,  32'h0F0F_0F0F, 32'h00FF_00FF); check("b2b_and", 32'h000F_000F, 32'd0);
    step(5'd1,  32'h0F0F_0F0F, 32'h00FF_00FF); check("b2b_or",  32'h0FFF_0FFF, 32'd0);
    step(5'd12, 32'h0F0F_0F0F, 32'h00FF_00FF); check("b2b_not", 32'hFF00_FF00, 32'd0);
    step(5'd20, 32'h0F0F_0F0F, 32'h00FF_00FF); check("b2b_rsv20", 32'd0, 32'd0);
    step(5'd2,  32'd1, 32'd1);                 check("b2b_add", 32'd2, 32'd0);
    step(5'd31, 32'hFFFF_FFFF, 32'hFFFF_FFFF); check("rsv31", 32'd0, 32'd0);

    // Outputs hold while inputs change between edges.
    step(5'd1, 32'hA5A5_0000, 32'h0000_5A5A); check("hold_pre", 32'hA5A5_5A5A, 32'd0);
    @(negedge clk);
    bus.op = 5'd9;
    bus.A  = 32'hFFFF_FFFF;
    bus.B  = 32'hFFFF_FFFF;
    #1;
    check("hold_mid", 32'hA5A5_5A5A, 32'd0);
    @(posedge clk);
    #1;
    check("hold_post", 32'd1, 32'd0);

    // Mid-stream reset discards the captured result, then operation resumes.
    @(negedge clk);
    clear  = 1'b0;
    bus.op = 5'd2;
    bus.A  = 32'hFFFF_FFFF;
    bus.B  = 32'd1;
    @(posedge clk);
    #1;
    check("mid_reset", 32'd0, 32'd0);
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1;
    check("resume", 32'd0, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
